// File: rtl/inst_fetch_pkg.sv
// inst_fetch_pkg
//   Shared definitions for the instruction fetch unit: FSM state encoding,
//   the opcode/function values that identify HLT, and the bit positions of
//   the instruction fields that feed the downstream register file.
package inst_fetch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        VALID = 2'd2,
        HALT  = 2'd3
    } state_t;

    localparam logic [3:0] OPC_RTYPE = 4'hF;
    localparam logic [5:0] FUNC_HLT  = 6'd29;

    // Field positions inside a 16-bit instruction word.
    localparam int OPC_HI  = 15;
    localparam int OPC_LO  = 12;
    localparam int RS_HI   = 11;
    localparam int RS_LO   = 10;
    localparam int RT_HI   = 9;
    localparam int RT_LO   = 8;
    localparam int RD_HI   = 7;
    localparam int RD_LO   = 6;
    localparam int FUNC_HI = 5;
    localparam int FUNC_LO = 0;

    // HLT is the R-type opcode with function code 29.
    function automatic logic is_hlt(input logic [15:0] w);
        return (w[OPC_HI:OPC_LO] == OPC_RTYPE) && (w[FUNC_HI:FUNC_LO] == FUNC_HLT);
    endfunction

endpackage

// File: rtl/inst_fetch.sv
// inst_fetch
//   Fetches instructions over a request/ready handshake, holds the current
//   one in an instruction register, and advances the PC (sequentially or to a
//   redirect target) each time downstream consumes it. Stops for good on HLT.
//
// Ports
//   clk, reset_n            clock, asynchronous active-low reset
//   i_readM, i_address      memory read request and address (held while requesting)
//   i_data, inputReady      returned instruction word and its ready strobe
//   stall                   downstream cannot consume this cycle
//   branch_valid/target     redirect applied on the consume edge
//   inst, inst_valid, pc    instruction register, its valid flag and address
//   rs, rt, rd              register-file address fields sliced from inst
//   num_inst                count of consumed instructions (wraps)
//   halted                  HLT was consumed; fetch is stopped
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter int              WORD     = 16,
    parameter logic [WORD-1:0] PC_RESET = '0
) (
    input  logic            clk,
    input  logic            reset_n,
    output logic            i_readM,
    output logic [WORD-1:0] i_address,
    input  logic [WORD-1:0] i_data,
    input  logic            inputReady,
    input  logic            stall,
    input  logic            branch_valid,
    input  logic [WORD-1:0] branch_target,
    output logic [WORD-1:0] inst,
    output logic            inst_valid,
    output logic [WORD-1:0] pc,
    output logic [1:0]      rs,
    output logic [1:0]      rt,
    output logic [1:0]      rd,
    output logic [WORD-1:0] num_inst,
    output logic            halted
);

    state_t          state, state_n;
    logic [WORD-1:0] pc_q, pc_n;
    logic [WORD-1:0] inst_q, inst_n;
    logic [WORD-1:0] cnt_q, cnt_n;
    logic            consume;

    // A consume is an edge in VALID with no downstream stall.
    assign consume = (state == VALID) && !stall;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            pc_q   <= PC_RESET;
            inst_q <= '0;
            cnt_q  <= '0;
        end else begin
            state  <= state_n;
            pc_q   <= pc_n;
            inst_q <= inst_n;
            cnt_q  <= cnt_n;
        end
    end

    always_comb begin
        state_n = state;
        pc_n    = pc_q;
        inst_n  = inst_q;
        cnt_n   = cnt_q;
        case (state)
            IDLE: state_n = FETCH;
            FETCH: begin
                if (inputReady) begin
                    inst_n  = i_data;
                    state_n = VALID;
                end
            end
            VALID: begin
                if (consume) begin
                    cnt_n = cnt_q + WORD'(1);
                    // HLT takes priority over any redirect and leaves pc alone.
                    if (is_hlt(inst_q[15:0])) begin
                        state_n = HALT;
                    end else begin
                        pc_n    = branch_valid ? branch_target : pc_q + WORD'(1);
                        state_n = FETCH;
                    end
                end
            end
            HALT: state_n = HALT;
            default: state_n = IDLE;
        endcase
    end

    assign i_readM    = (state == FETCH);
    assign i_address  = pc_q;
    assign inst_valid = (state == VALID);
    assign halted     = (state == HALT);
    assign inst       = inst_q;
    assign pc         = pc_q;
    assign num_inst   = cnt_q;

    // Plain wiring: stable for the whole VALID period for the RF's comb read.
    assign rs = inst_q[RS_HI:RS_LO];
    assign rt = inst_q[RT_HI:RT_LO];
    assign rd = inst_q[RD_HI:RD_LO];

endmodule

// File: tb/tb_inst_fetch.sv
module tb_inst_fetch;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        i_readM;
    logic [15:0] i_address;
    logic [15:0] i_data;
    logic        inputReady;
    logic        stall;
    logic        branch_valid;
    logic [15:0] branch_target;
    logic [15:0] inst;
    logic        inst_valid;
    logic [15:0] pc;
    logic [1:0]  rs, rt, rd;
    logic [15:0] num_inst;
    logic        halted;

    int errors = 0;
    int checks = 0;

    inst_fetch #(.WORD(16), .PC_RESET(16'h0000)) dut (
        .clk(clk), .reset_n(reset_n), .i_readM(i_readM), .i_address(i_address),
        .i_data(i_data), .inputReady(inputReady), .stall(stall),
        .branch_valid(branch_valid), .branch_target(branch_target),
        .inst(inst), .inst_valid(inst_valid), .pc(pc), .rs(rs), .rt(rt), .rd(rd),
        .num_inst(num_inst), .halted(halted)
    );

    always #5 clk = ~clk;

    // Advance one rising edge and settle before sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        inputReady = 1'b0; stall = 1'b0; branch_valid = 1'b0;
        branch_target = 16'h0; i_data = 16'h0;
        step(); step();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        reset_n = 1'b0;
        #1;
        checks++; if (i_readM !== 1'b0) begin errors++; $display("FAIL reset_readM got %b want 0", i_readM); end
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", inst_valid); end
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted got %b want 0", halted); end
        checks++; if ({inst, pc, num_inst} !== 48'h0) begin errors++; $display("FAIL reset_regs got %h/%h/%h want 0/0/0", inst, pc, num_inst); end
        checks++; if ({rs, rt, rd} !== 6'h0) begin errors++; $display("FAIL reset_fields got %b want 000000", {rs, rt, rd}); end
        reset_n = 1'b1;
        step();
        checks++; if (i_readM !== 1'b1 || i_address !== 16'h0000) begin errors++; $display("FAIL first_fetch got readM=%b addr=%h want 1/0000", i_readM, i_address); end
    endtask

    // Memory answers immediately; stall held so the instruction stays put.
    task automatic test_zero_wait();
        i_data = 16'h1234; inputReady = 1'b1; stall = 1'b1;
        step();
        inputReady = 1'b0;
        checks++; if (inst !== 16'h1234 || pc !== 16'h0 || inst_valid !== 1'b1) begin errors++; $display("FAIL zero_wait got inst=%h pc=%h v=%b want 1234/0000/1", inst, pc, inst_valid); end
        checks++; if (rs !== 2'd0 || rt !== 2'd2 || rd !== 2'd0) begin errors++; $display("FAIL fields got rs=%0d rt=%0d rd=%0d want 0/2/0", rs, rt, rd); end
        checks++; if (i_readM !== 1'b0) begin errors++; $display("FAIL valid_readM got %b want 0", i_readM); end
    endtask

    task automatic test_stall();
        stall = 1'b1; branch_valid = 1'b1; branch_target = 16'h0AAA;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++; if (inst !== 16'h1234 || pc !== 16'h0 || num_inst !== 16'h0 || inst_valid !== 1'b1) begin
                errors++; $display("FAIL stall_hold[%0d] got inst=%h pc=%h n=%h v=%b", i, inst, pc, num_inst, inst_valid); end
        end
        stall = 1'b0; branch_valid = 1'b0;
        step();
        checks++; if (pc !== 16'h1 || num_inst !== 16'h1 || i_readM !== 1'b1 || i_address !== 16'h1) begin
            errors++; $display("FAIL stall_release got pc=%h n=%h readM=%b addr=%h want 0001/0001/1/0001", pc, num_inst, i_readM, i_address); end
    endtask

    task automatic test_delayed_ready();
        inputReady = 1'b0; i_data = 16'hDEAD; stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (i_readM !== 1'b1 || i_address !== 16'h1 || inst !== 16'h1234 || inst_valid !== 1'b0) begin
                errors++; $display("FAIL wait[%0d] got readM=%b addr=%h inst=%h v=%b", i, i_readM, i_address, inst, inst_valid); end
        end
        i_data = 16'hABCD; inputReady = 1'b1;
        step();
        inputReady = 1'b0;
        checks++; if (inst !== 16'hABCD || inst_valid !== 1'b1 || pc !== 16'h1) begin
            errors++; $display("FAIL delayed_capture got inst=%h v=%b pc=%h want abcd/1/0001", inst, inst_valid, pc); end
    endtask

    task automatic test_branch();
        stall = 1'b0; branch_valid = 1'b1; branch_target = 16'h0040;
        step();
        checks++; if (i_address !== 16'h0040 || i_readM !== 1'b1 || num_inst !== 16'd2) begin
            errors++; $display("FAIL branch got addr=%h readM=%b n=%0d want 0040/1/2", i_address, i_readM, num_inst); end
        // Redirect outside a consume must be ignored.
        branch_target = 16'h0099; i_data = 16'h0000; inputReady = 1'b1; stall = 1'b1;
        step();
        inputReady = 1'b0;
        checks++; if (pc !== 16'h0040 || inst_valid !== 1'b1) begin errors++; $display("FAIL branch_ignored got pc=%h v=%b want 0040/1", pc, inst_valid); end
        stall = 1'b0; branch_target = 16'hFFFF;
        step();
        checks++; if (i_address !== 16'hFFFF) begin errors++; $display("FAIL branch_ffff got %h want ffff", i_address); end
    endtask

    task automatic test_wrap();
        branch_valid = 1'b0; i_data = 16'h1111; inputReady = 1'b1; stall = 1'b1;
        step();
        inputReady = 1'b0; stall = 1'b0;
        step();
        checks++; if (pc !== 16'h0000 || i_address !== 16'h0000 || num_inst !== 16'd4) begin
            errors++; $display("FAIL pc_wrap got pc=%h addr=%h n=%0d want 0000/0000/4", pc, i_address, num_inst); end
    endtask

    task automatic test_halt();
        do_reset();
        step();
        i_data = 16'hF01D; inputReady = 1'b1; stall = 1'b1;
        step();
        inputReady = 1'b0;
        checks++; if (inst !== 16'hF01D || inst_valid !== 1'b1) begin errors++; $display("FAIL hlt_load got inst=%h v=%b", inst, inst_valid); end
        stall = 1'b0; branch_valid = 1'b1; branch_target = 16'h0055;
        step();
        branch_valid = 1'b0;
        checks++; if (halted !== 1'b1 || i_readM !== 1'b0 || inst_valid !== 1'b0) begin
            errors++; $display("FAIL halt got halted=%b readM=%b v=%b want 1/0/0", halted, i_readM, inst_valid); end
        checks++; if (pc !== 16'h0000 || num_inst !== 16'd1) begin errors++; $display("FAIL halt_regs got pc=%h n=%0d want 0000/1", pc, num_inst); end
        inputReady = 1'b1; i_data = 16'h2222;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++; if (halted !== 1'b1 || i_readM !== 1'b0 || inst !== 16'hF01D || num_inst !== 16'd1) begin
                errors++; $display("FAIL halt_stay[%0d] got halted=%b readM=%b inst=%h n=%0d", i, halted, i_readM, inst, num_inst); end
        end
        inputReady = 1'b0;
    endtask

    task automatic test_reset_mid_fetch();
        do_reset();
        step();
        checks++; if (i_readM !== 1'b1) begin errors++; $display("FAIL pre_reset_fetch got %b want 1", i_readM); end
        #2 reset_n = 1'b0;
        #1;
        checks++; if (i_readM !== 1'b0) begin errors++; $display("FAIL async_drop got %b want 0", i_readM); end
        i_data = 16'h7777; inputReady = 1'b1;
        step();
        checks++; if (inst !== 16'h0 || inst_valid !== 1'b0 || i_readM !== 1'b0) begin
            errors++; $display("FAIL reset_ignore got inst=%h v=%b readM=%b want 0000/0/0", inst, inst_valid, i_readM); end
        inputReady = 1'b0;
        reset_n = 1'b1;
        step();
        checks++; if (i_readM !== 1'b1 || i_address !== 16'h0000) begin errors++; $display("FAIL restart got readM=%b addr=%h want 1/0000", i_readM, i_address); end
    endtask

    // Random traffic against a model that tracks the fetch/hold/halt phases
    // directly from the handshake rules.
    task automatic test_random();
        bit          m_fetching, m_holding, m_started;
        logic [15:0] m_pc, m_inst, m_cnt, d;
        do_reset();
        m_started = 0; m_fetching = 0; m_holding = 0;
        m_pc = 16'h0; m_inst = 16'h0; m_cnt = 16'h0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            d = 16'($urandom);
            if (d[15:12] == 4'hF && d[5:0] == 6'd29) d[0] = ~d[0];
            i_data = d;
            inputReady = ($urandom_range(0, 2) != 0);
            stall = ($urandom_range(0, 2) == 0);
            branch_valid = ($urandom_range(0, 3) == 0);
            branch_target = 16'($urandom);
            if (!m_started) begin
                m_started = 1; m_fetching = 1;
            end else if (m_fetching) begin
                if (inputReady) begin m_inst = d; m_fetching = 0; m_holding = 1; end
            end else if (m_holding && !stall) begin
                m_cnt = m_cnt + 16'd1;
                m_pc = branch_valid ? branch_target : m_pc + 16'd1;
                m_holding = 0; m_fetching = 1;
            end
            step();
            checks++; if (i_readM !== m_fetching || inst_valid !== m_holding || halted !== 1'b0) begin
                errors++; $display("FAIL rnd_ctrl[%0d] got readM=%b v=%b h=%b want %b/%b/0", cyc, i_readM, inst_valid, halted, m_fetching, m_holding); end
            checks++; if (pc !== m_pc || i_address !== m_pc) begin errors++; $display("FAIL rnd_pc[%0d] got pc=%h addr=%h want %h", cyc, pc, i_address, m_pc); end
            checks++; if (inst !== m_inst || num_inst !== m_cnt) begin errors++; $display("FAIL rnd_inst[%0d] got inst=%h n=%h want %h/%h", cyc, inst, num_inst, m_inst, m_cnt); end
            checks++; if ({rs, rt, rd} !== {m_inst[11:10], m_inst[9:8], m_inst[7:6]}) begin
                errors++; $display("FAIL rnd_fields[%0d] got %b want %b", cyc, {rs, rt, rd}, {m_inst[11:10], m_inst[9:8], m_inst[7:6]}); end
        end
        inputReady = 1'b0; stall = 1'b0; branch_valid = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0;
        inputReady = 1'b0; stall = 1'b0; branch_valid = 1'b0;
        branch_target = 16'h0; i_data = 16'h0;
        test_reset();
        test_zero_wait();
        test_stall();
        test_delayed_ready();
        test_branch();
        test_wrap();
        test_halt();
        test_reset_mid_fetch();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
